// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: write-back bypass, register-zero rule, load-use bubble, hold and flush.
// Optional macro HAZARD_STATS_EN builds a saturating load-use stall counter on hazard_cnt.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_PR1,
  input  logic [REG_AW-1:0] id_PR2,
  input  logic [DATA_W-1:0] id_RD1,
  input  logic [DATA_W-1:0] id_RD2,
  input  logic [REG_AW-1:0] id_WR,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              wb_write,
  input  logic [REG_AW-1:0] wb_WR,
  input  logic [DATA_W-1:0] wb_WD,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              id_stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_A,
  output logic [DATA_W-1:0] ex_B,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_PR1,
  output logic [REG_AW-1:0] ex_PR2,
  output logic [REG_AW-1:0] ex_WR,
  output logic [15:0]       hazard_cnt
);

  logic              r_valid, r_reg_write, r_mem_read;
  logic [DATA_W-1:0] r_A, r_B, r_imm;
  logic [REG_AW-1:0] r_PR1, r_PR2, r_WR;

  logic [DATA_W-1:0] w_opA, w_opB;
  logic              w_load_use;
  logic              w_take;

  // Register zero reads 0 even when write-back targets it.
  always_comb begin
    w_opA = id_RD1;
    if (id_PR1 == '0)                      w_opA = '0;
    else if (wb_write && wb_WR == id_PR1)  w_opA = wb_WD;
  end

  always_comb begin
    w_opB = id_RD2;
    if (id_PR2 == '0)                      w_opB = '0;
    else if (wb_write && wb_WR == id_PR2)  w_opB = wb_WD;
  end

  assign w_load_use = id_valid && r_valid && r_mem_read && (r_WR != '0) &&
                      ((id_PR1 == r_WR) || (id_PR2 == r_WR));
  assign id_stall   = !reset && (w_load_use || ex_hold);
  assign w_take     = id_valid && !flush && !w_load_use;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_A         <= '0;
      r_B         <= '0;
      r_imm       <= '0;
      r_PR1       <= '0;
      r_PR2       <= '0;
      r_WR        <= '0;
    end else if (!ex_hold) begin
      // Flush and bubble only kill control; data fields are don't-care then.
      r_valid     <= w_take;
      r_reg_write <= w_take && id_reg_write;
      r_mem_read  <= w_take && id_mem_read;
      r_A         <= w_opA;
      r_B         <= w_opB;
      r_imm       <= id_imm;
      r_PR1       <= id_PR1;
      r_PR2       <= id_PR2;
      r_WR        <= id_WR;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_reg_write = r_reg_write;
  assign ex_mem_read  = r_mem_read;
  assign ex_A         = r_A;
  assign ex_B         = r_B;
  assign ex_imm       = r_imm;
  assign ex_PR1       = r_PR1;
  assign ex_PR2       = r_PR2;
  assign ex_WR        = r_WR;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_hazard_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_hazard_cnt <= '0;
    else if (w_load_use && !ex_hold && r_hazard_cnt != 16'hFFFF)
      r_hazard_cnt <= r_hazard_cnt + 16'd1;
  end

  assign hazard_cnt = r_hazard_cnt;
`else
  assign hazard_cnt = '0;
`endif

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register between the register file read (decode) stage and the execute stage. It captures the decoded operand values, applies write-back bypassing and the register-zero rule, and detects load-use hazards. On a hazard it stalls decode and inserts a bubble. It also supports a downstream hold and a branch flush.

## Interface
Parameters:
- DATA_W, 32, operand and immediate width
- REG_AW, 5, register address width

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_PR1, id_PR2  in  REG_AW  source register addresses, same values presented to reg_file PR1/PR2
- id_RD1, id_RD2  in  DATA_W  reg_file read data
- id_WR  in  REG_AW  destination register
- id_reg_write  in  1  instruction writes a register
- id_mem_read  in  1  instruction is a load
- id_imm  in  DATA_W  sign-extended immediate
- wb_write, wb_WR, wb_WD  in  1/REG_AW/DATA_W  write-back port, same values driven to reg_file write/WR/WD
- flush  in  1  branch taken, squash decode slot
- ex_hold  in  1  execute stage cannot accept, freeze EX registers
- id_stall  out  1  hold PC and IF/ID (combinational)
- ex_valid, ex_reg_write, ex_mem_read  out  1  registered control
- ex_A, ex_B, ex_imm  out  DATA_W  registered operands and immediate
- ex_PR1, ex_PR2, ex_WR  out  REG_AW  registered addresses, for the forwarding unit
- hazard_cnt  out  16  load-use stall cycle count

## Operation
- Operand select, per source n:
  - If id_PRn==0, select 0.
  - Else if wb_write && wb_WR==id_PRn, select wb_WD (bypass).
  - Else select id_RDn.
- Load-use hazard:
  - load_use = id_valid && ex_valid && ex_mem_read && ex_WR!=0 && (id_PR1==ex_WR || id_PR2==ex_WR).
  - id_stall = !reset && (load_use || ex_hold).
- Register update per cycle, highest priority first:
  1. reset: all registered outputs ← 0.
  2. ex_hold: all EX registers keep their value. flush is ignored here; IF/ID squashes its own slot.
  3. flush: ex_valid, ex_reg_write and ex_mem_read ← 0. Data fields load normally (don't-care).
  4. load_use: bubble; ex_valid, ex_reg_write and ex_mem_read ← 0. Decode is held by id_stall, so the same instruction is re-presented next cycle.
  5. Otherwise: load all fields from ID. Control bits are ANDed with id_valid.
- ex_A and ex_B are captured with the bypassed values. ex_imm passes through unchanged.

## Timing
- Latency: 1 cycle, ID inputs at edge N appear on ex_* after edge N.
- id_stall is combinational from ex_* registers, id_* and ex_hold. There is no registered path.
- A load-use stall lasts exactly 1 cycle. After the bubble, ex_valid=0, so load_use deasserts.
- Bypass and reg_file write in the same cycle: the bypassed value is captured, so there is no stale read.
- wb_WR==0 with wb_write=1: no bypass, operand reads 0.
- Reset mid-stall: id_stall drops in the reset cycle and all ex_* are 0 the next cycle.
- Reset values: every ex_* output 0, hazard_cnt 0, id_stall 0.

## Configuration
- HAZARD_STATS_EN defined: hazard_cnt increments by 1 on every rising edge where load_use=1 and ex_hold=0. It saturates at 16'hFFFF and is cleared only by reset.
- HAZARD_STATS_EN undefined: hazard_cnt is tied to 0 and no counter flops are built.

## Test plan
- Reset, then id_valid=1, PR1=6, PR2=8, RD1=6, RD2=8 → next cycle ex_A=6, ex_B=8, ex_valid=1, id_stall=0.
- PR1=4, id_RD1=0, wb_write=1, wb_WR=4, wb_WD=31 in the same cycle → ex_A=31. With PR1=0 and wb_WR=0, wb_WD=55 → ex_A=0.
- Load with WR=3 in EX, then ID with PR2=3 → id_stall=1 for 1 cycle and a bubble (ex_valid=0). The following cycle loads the dependent instruction and id_stall=0. With HAZARD_STATS_EN, hazard_cnt=1.
- ex_hold=1 for 3 cycles with changing ID inputs → ex_* unchanged and id_stall=1. ex_hold together with flush → EX still unchanged.
- flush=1 with a valid ID instruction (reg_write=1) → next cycle ex_valid=0 and ex_reg_write=0.
- reset asserted during a load-use stall → same cycle id_stall=0, next cycle all ex_*=0 and hazard_cnt=0.
